pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter and return-address-stack block for the FRANK6000 core.
- Responder to the control unit's sequencing outputs: jump, j_mode, call, return, PCw.
- Holds the PC, pushes return addresses on CALLS, pops them on RETRN, and selects the next PC each time PCw is asserted.
- Drives the instruction-memory address and reports stack faults in sticky status bits.

Parameters:
- PC_W, 8, program counter / address width in bits.
- DEPTH, 4, return-stack entries (power of 2, ≥2).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_en  in  1  global enable; when low all state holds.
- i_jump  in  1  jump request from the control unit.
- i_j_mode  in  2  next-PC source select.
- i_call  in  1  push return address.
- i_return  in  1  pop top of stack into the return latch.
- i_PCw  in  1  PC write strobe.
- i_target  in  PC_W  absolute jump target (instruction immediate).
- o_pc  out  PC_W  current PC / instruction address.
- o_sp  out  $clog2(DEPTH)+1  stack occupancy, 0..DEPTH.
- o_overflow  out  1  sticky: push while full.
- o_underflow  out  1  sticky: pop while empty.

Behaviour:
- Reset: o_pc=0, o_sp=0, ret_latch=0, o_overflow=0, o_underflow=0, all stack entries=0. Reset mid-operation discards any pending push or pop in the same cycle.
- i_en=0: no state changes; all inputs are ignored.
- Next-PC selection, applied only when i_PCw=1, in priority order:
  - i_jump=1 and j_mode=01: PC <= i_target (absolute).
  - j_mode=10: PC <= ret_latch (return). i_jump is ignored for this mode.
  - i_jump=1 and j_mode=11: PC <= PC+2 (skip next instruction).
  - Otherwise: PC <= PC+1.
  - All PC arithmetic is modulo 2^PC_W; 2^PC_W-1 increments to 0.
- i_PCw=0: PC holds.
- Push (i_call=1, i_PCw=1, i_jump=1, j_mode=01):
  - stack[sp] <= PC+1 (the value before the update), then sp <= sp+1.
  - The push and the PC load happen in the same cycle; latency is 1 clock.
  - i_call without i_PCw is ignored.
- Pop (i_return=1):
  - ret_latch <= stack[sp-1], then sp <= sp-1.
  - The PC is not changed that cycle. The control unit applies j_mode=10 with PCw on the following cycle (two-cycle RETRN), so pop-to-PC latency is 2 clocks.
- Simultaneous i_call and i_return: the return is ignored and the push proceeds. A counter test covers this case.
- Full (sp==DEPTH) and push: o_overflow <= 1; stack and sp unchanged; PC still updates.
- Empty (sp==0) and pop: o_underflow <= 1; sp stays 0; ret_latch <= 0.
- Sticky flags clear only on i_rst.
- o_pc and o_sp are driven directly from registers; there is no combinational path from inputs.

Optional Feature:
- Macro: PC_STACK_CIRCULAR_EN.
- Defined:
  - The stack is a ring. A push when full overwrites the oldest entry: the write index wraps and sp saturates at DEPTH.
  - A pop when empty returns the entry at the wrapped index and does not clamp.
  - o_overflow and o_underflow are still set.
- Undefined: saturating behaviour as described in Behaviour.

Decomposition:
- Shared package/macro header pc_sequencer_macro.v holds the j_mode encodings: JM_SEQ=2'b00, JM_ABS=2'b01, JM_RET=2'b10, JM_SKIP=2'b11.
- One sub-module, return_stack: the register file plus sp, push/pop, full/empty and the circular option.
- The top level contains the PC register, the next-PC mux and ret_latch.

Test Plan:
- Reset then 5 cycles of i_PCw=1, j_mode=00 -> o_pc steps 0,1,2,3,4,5; o_sp=0.
- At PC=0x10: i_call, i_jump, j_mode=01, i_target=0x40, i_PCw -> next cycle o_pc=0x40, o_sp=1, stack[0]=0x11.
- From that state, i_return, then i_PCw with j_mode=10 -> o_pc=0x11 exactly 2 cycles after i_return; o_sp=0.
- DEPTH=4: five nested calls -> o_sp=4, o_overflow=1, stack top still holds the 4th return address. With PC_STACK_CIRCULAR_EN, the 5th address overwrites the oldest entry.
- PC=0xFF: i_PCw, j_mode=00 -> o_pc=0x00. PC=0xFE: skip (i_jump, j_mode=11) -> o_pc=0x00.
- i_return with sp=0 -> o_underflow=1, ret_latch=0. Then i_rst=1 for one clock -> all outputs 0. Also: i_en=0 with i_PCw=1 -> o_pc holds.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: next-PC source encodings shared by the sequencer files.
package pc_sequencer_pkg;
  typedef enum logic [1:0] {
    JM_SEQ  = 2'b00,
    JM_ABS  = 2'b01,
    JM_RET  = 2'b10,
    JM_SKIP = 2'b11
  } j_mode_e;
endpackage

// File: rtl/pc_sequencer_return_stack.sv
// pc_sequencer_return_stack: return-address stack with sticky faults; PC_STACK_CIRCULAR_EN turns it into a ring.
module pc_sequencer_return_stack #(
  parameter int PC_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [PC_W-1:0]          i_data,
  output logic [PC_W-1:0]          o_top,
  output logic [$clog2(DEPTH):0]   o_sp,
  output logic                     o_overflow,
  output logic                     o_underflow
);
  localparam int AW = $clog2(DEPTH);
`ifdef PC_STACK_CIRCULAR_EN
  localparam bit RING = 1'b1;
`else
  localparam bit RING = 1'b0;
`endif
  logic [PC_W-1:0] mem [DEPTH];
  logic [AW-1:0]   head, prev;
  logic            full, empty, wr, rd;
  assign full  = o_sp == (AW+1)'(DEPTH);
  assign empty = o_sp == '0;
  assign prev  = head - 1'b1;
  assign wr    = i_push & (RING | ~full);
  assign rd    = i_pop & (RING | ~empty);
  assign o_top = rd ? mem[prev] : '0;
  // head tracks the write slot; in saturating mode it always equals the low bits of sp
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head        <= '0;
      o_sp        <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr) begin
        mem[head] <= i_data;
        head      <= head + 1'b1;
        if (!full) o_sp <= o_sp + 1'b1;
      end else if (rd) begin
        head <= prev;
        if (!empty) o_sp <= o_sp - 1'b1;
      end
      if (i_push && full) o_overflow <= 1'b1;
      if (i_pop && empty) o_underflow <= 1'b1;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, next-PC mux and return latch over a return stack (PC_STACK_CIRCULAR_EN selects ring stack).
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_jump,
  input  logic [1:0]             i_j_mode,
  input  logic                   i_call,
  input  logic                   i_return,
  input  logic                   i_PCw,
  input  logic [PC_W-1:0]        i_target,
  output logic [PC_W-1:0]        o_pc,
  output logic [$clog2(DEPTH):0] o_sp,
  output logic                   o_overflow,
  output logic                   o_underflow
);
  j_mode_e         jm;
  logic [PC_W-1:0] ret_latch, top, pc_inc, next_pc;
  logic            push, pop;
  assign jm     = j_mode_e'(i_j_mode);
  assign pc_inc = o_pc + 1'b1;
  assign push   = i_en & i_call & i_PCw & i_jump & (jm == JM_ABS);
  // a call wins over a simultaneous return
  assign pop    = i_en & i_return & ~push;
  always_comb begin
    next_pc = (i_jump && jm == JM_ABS) ? i_target :
              (jm == JM_RET) ? ret_latch :
              (i_jump && jm == JM_SKIP) ? o_pc + PC_W'(2) : pc_inc;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pc      <= '0;
      ret_latch <= '0;
    end else begin
      if (i_en && i_PCw) o_pc <= next_pc;
      if (pop) ret_latch <= top;
    end
  end
  pc_sequencer_return_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) u_stack (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push),
    .i_pop       (pop),
    .i_data      (pc_inc),
    .o_top       (top),
    .o_sp        (o_sp),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with a queued scoreboard checked by an independent monitor.
module tb_pc_sequencer;
`ifdef PC_STACK_CIRCULAR_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif
  typedef struct {
    logic [7:0] pc;
    logic [2:0] sp;
    logic       ovf;
    logic       unf;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst, en, jump, call, ret, pcw;
  logic [1:0] jm;
  logic [7:0] tgt;
  logic [7:0] pc;
  logic [2:0] sp;
  logic       ovf, unf;
  exp_t       q[$];
  string      names[$];
  int         checks = 0;
  int         failures = 0;
  always #5 clk = ~clk;
  pc_sequencer #(.PC_W(8), .DEPTH(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_jump      (jump),
    .i_j_mode    (jm),
    .i_call      (call),
    .i_return    (ret),
    .i_PCw       (pcw),
    .i_target    (tgt),
    .o_pc        (pc),
    .o_sp        (sp),
    .o_overflow  (ovf),
    .o_underflow (unf)
  );
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t  e;
      string n;
      e = q.pop_front();
      n = names.pop_front();
      checks++;
      if (pc !== e.pc || sp !== e.sp || ovf !== e.ovf || unf !== e.unf) begin
        failures++;
        $display("FAIL %s: got pc=%h sp=%0d ovf=%b unf=%b, want pc=%h sp=%0d ovf=%b unf=%b",
                 n, pc, sp, ovf, unf, e.pc, e.sp, e.ovf, e.unf);
      end
    end
  end
  task automatic v(input string n, input logic r, input logic e, input logic w, input logic j,
                   input logic [1:0] m, input logic c, input logic rt, input logic [7:0] t,
                   input logic [7:0] epc, input logic [2:0] esp, input logic eo, input logic eu);
    exp_t x;
    rst = r; en = e; pcw = w; jump = j; jm = m; call = c; ret = rt; tgt = t;
    @(posedge clk);
    x.pc = epc; x.sp = esp; x.ovf = eo; x.unf = eu;
    q.push_back(x);
    names.push_back(n);
    #1;
  endtask
  initial begin
    //   name         rst en pcw jmp jm     call ret tgt     pc      sp ovf unf
    v("reset",        1, 1, 0, 0, 2'b00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    v("seq1",         0, 1, 1, 0, 2'b00, 0, 0, 8'h00, 8'h01, 0, 0, 0);
    v("seq2",         0, 1, 1, 0, 2'b00, 0, 0, 8'h00, 8'h02, 0, 0, 0);
    v("seq3",         0, 1, 1, 0, 2'b00, 0, 0, 8'h00, 8'h03, 0, 0, 0);
    v("seq4",         0, 1, 1, 0, 2'b00, 0, 0, 8'h00, 8'h04, 0, 0, 0);
    v("seq5",         0, 1, 1, 0, 2'b00, 0, 0, 8'h00, 8'h05, 0, 0, 0);
    v("jmp10",        0, 1, 1, 1, 2'b01, 0, 0, 8'h10, 8'h10, 0, 0, 0);
    v("call40",       0, 1, 1, 1, 2'b01, 1, 0, 8'h40, 8'h40, 1, 0, 0);
    v("pop1",         0, 1, 0, 0, 2'b00, 0, 1, 8'h00, 8'h40, 0, 0, 0);
    v("ret11",        0, 1, 1, 0, 2'b10, 0, 0, 8'h00, 8'h11, 0, 0, 0);
    v("nest1",        0, 1, 1, 1, 2'b01, 1, 0, 8'h20, 8'h20, 1, 0, 0);
    v("nest2",        0, 1, 1, 1, 2'b01, 1, 0, 8'h30, 8'h30, 2, 0, 0);
    v("nest3",        0, 1, 1, 1, 2'b01, 1, 0, 8'h50, 8'h50, 3, 0, 0);
    v("nest4",        0, 1, 1, 1, 2'b01, 1, 0, 8'h60, 8'h60, 4, 0, 0);
    v("nest5_ovf",    0, 1, 1, 1, 2'b01, 1, 0, 8'h70, 8'h70, 4, 1, 0);
    v("pop_top",      0, 1, 0, 0, 2'b00, 0, 1, 8'h00, 8'h70, 3, 1, 0);
    v("ret_top",      0, 1, 1, 0, 2'b10, 0, 0, 8'h00, CIRC ? 8'h61 : 8'h51, 3, 1, 0);
    v("call_and_ret", 0, 1, 1, 1, 2'b01, 1, 1, 8'h80, 8'h80, 4, 1, 0);
    v("pop_after",    0, 1, 0, 0, 2'b00, 0, 1, 8'h00, 8'h80, 3, 1, 0);
    v("ret_jmpign",   0, 1, 1, 1, 2'b10, 0, 0, 8'h00, CIRC ? 8'h62 : 8'h52, 3, 1, 0);
    v("pop_a",        0, 1, 0, 0, 2'b00, 0, 1, 8'h00, CIRC ? 8'h62 : 8'h52, 2, 1, 0);
    v("pop_b",        0, 1, 0, 0, 2'b00, 0, 1, 8'h00, CIRC ? 8'h62 : 8'h52, 1, 1, 0);
    v("pop_c",        0, 1, 0, 0, 2'b00, 0, 1, 8'h00, CIRC ? 8'h62 : 8'h52, 0, 1, 0);
    v("ret_bottom",   0, 1, 1, 0, 2'b10, 0, 0, 8'h00, CIRC ? 8'h21 : 8'h12, 0, 1, 0);
    v("pop_empty",    0, 1, 0, 0, 2'b00, 0, 1, 8'h00, CIRC ? 8'h21 : 8'h12, 0, 1, 1);
    v("ret_empty",    0, 1, 1, 0, 2'b10, 0, 0, 8'h00, CIRC ? 8'h62 : 8'h00, 0, 1, 1);
    v("en0_pcw",      0, 0, 1, 0, 2'b00, 0, 0, 8'h00, CIRC ? 8'h62 : 8'h00, 0, 1, 1);
    v("en0_call",     0, 0, 1, 1, 2'b01, 1, 0, 8'h99, CIRC ? 8'h62 : 8'h00, 0, 1, 1);
    v("reset2",       1, 1, 0, 0, 2'b00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    v("jmpFF",        0, 1, 1, 1, 2'b01, 0, 0, 8'hFF, 8'hFF, 0, 0, 0);
    v("wrap_inc",     0, 1, 1, 0, 2'b00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    v("jmpFE",        0, 1, 1, 1, 2'b01, 0, 0, 8'hFE, 8'hFE, 0, 0, 0);
    v("wrap_skip",    0, 1, 1, 1, 2'b11, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    v("skip_nojump",  0, 1, 1, 0, 2'b11, 0, 0, 8'h00, 8'h01, 0, 0, 0);
    v("call_nopcw",   0, 1, 0, 1, 2'b01, 1, 0, 8'h40, 8'h01, 0, 0, 0);
    v("abs_nojump",   0, 1, 1, 0, 2'b01, 0, 0, 8'h40, 8'h02, 0, 0, 0);
    v("pcw_hold",     0, 1, 0, 0, 2'b00, 0, 0, 8'h00, 8'h02, 0, 0, 0);
    v("call_pre_rst", 0, 1, 1, 1, 2'b01, 1, 0, 8'h33, 8'h33, 1, 0, 0);
    v("rst_w_call",   1, 1, 1, 1, 2'b01, 1, 1, 8'h44, 8'h00, 0, 0, 0);
    v("post_rst_seq", 0, 1, 1, 0, 2'b00, 0, 0, 8'h00, 8'h01, 0, 0, 0);
    rst = 1'b0; en = 1'b0; pcw = 1'b0; call = 1'b0; ret = 1'b0; jump = 1'b0;
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
